// File: rtl/rf_burst_reader_pkg.sv
// rtl/rf_burst_reader_pkg.sv - shared constants for the burst reader and its register file
//
// Holds the reader FSM state encodings and the default word/address widths,
// so that the reader and reg_file are built to the same geometry.

package rf_burst_reader_pkg;

    // Default geometry shared with reg_file
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    // Reader FSM encodings (plain constants so legacy code can use them too)
    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_RUN  = 2'd1;
    localparam logic [1:0] RD_DONE = 2'd2;

    typedef logic [1:0] rd_state_t;

endpackage : rf_burst_reader_pkg

// File: rtl/rf_burst_reader_if.sv
// rtl/rf_burst_reader_if.sv - control, register-file and output-stream bundle of rf_burst_reader
//
// Signals:
//   start_i, base_i, len_i : burst request (start sampled only while idle)
//   busy_o, done_o         : status; done_o is a one-cycle completion pulse
//   ra_o, rd_i             : register-file read address / combinational read data
//   m_valid_o, m_data_o,
//   m_ready_i              : output word stream with full backpressure
// Modports:
//   slave  : the reader itself
//   master : the controlling/consuming side

interface rf_burst_reader_if
    import rf_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_i;
    logic [ADDR_WIDTH:0]   len_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] ra_o;
    logic [DATA_WIDTH-1:0] rd_i;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_ready_i;

    modport slave (
        input  start_i, base_i, len_i, rd_i, m_ready_i,
        output busy_o, done_o, ra_o, m_valid_o, m_data_o
    );

    modport master (
        output start_i, base_i, len_i, m_ready_i,
        input  busy_o, done_o, ra_o, m_valid_o, m_data_o, rd_i
    );

endinterface : rf_burst_reader_if

// File: rtl/rf_burst_reader_reg_file.sv
// rtl/rf_burst_reader_reg_file.sv - register file with one sync write port and one comb read port
//
// Ports:
//   clk   : clock, writes on the rising edge
//   we_i  : write enable
//   wa_i  : write address
//   wd_i  : write data
//   ra_i  : read address
//   rd_o  : read data, combinational on ra_i; address 0 always reads zero

module reg_file
    import rf_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wa_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic [ADDR_WIDTH-1:0] ra_i,
    output logic [DATA_WIDTH-1:0] rd_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Location 0 is hard-wired to zero regardless of what was written there
    assign rd_o = (ra_i == '0) ? '0 : mem_q[ra_i];

endmodule : reg_file

// File: rtl/rf_burst_reader.sv
// rtl/rf_burst_reader.sv - streams a wrapping address range of reg_file out as valid/ready words
//
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : rf_burst_reader_if.slave
//         start_i/base_i/len_i in, busy_o/done_o out,
//         ra_o out to reg_file, rd_i in from reg_file,
//         m_valid_o/m_data_o out, m_ready_i in
//
// One word is loaded per cycle while the output register is empty or being
// drained, giving full throughput with m_ready_i high. All outputs come from
// registers, so m_ready_i has no combinational path to any output.

module rf_burst_reader
    import rf_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    rf_burst_reader_if.slave  bus
);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [ADDR_WIDTH:0]   rem_q,   rem_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  load;
    logic                  accept;

    assign accept = valid_q & bus.m_ready_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        load    = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (bus.start_i) begin
                    addr_d  = bus.base_i;
                    rem_d   = bus.len_i;
                    state_d = (bus.len_i == '0) ? RD_DONE : RD_RUN;
                end
            end

            RD_RUN: begin
                // Refill whenever the output slot is empty or drains this cycle
                load = (rem_q != '0) && (!valid_q || bus.m_ready_i);
                if (load) begin
                    data_d  = bus.rd_i;
                    valid_d = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    rem_d   = rem_q - (ADDR_WIDTH + 1)'(1);
                end else if (accept) begin
                    valid_d = 1'b0;
                end

                // Finish once nothing is left to load and the slot is (being) emptied
                if ((rem_q == '0) && (accept || !valid_q)) begin
                    state_d = RD_DONE;
                end
            end

            RD_DONE: begin
                state_d = RD_IDLE;
            end

            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.ra_o      = addr_q;
    assign bus.m_valid_o = valid_q;
    assign bus.m_data_o  = data_q;
    assign bus.busy_o    = (state_q != RD_IDLE);
    assign bus.done_o    = (state_q == RD_DONE);

endmodule : rf_burst_reader

// File: tb/tb_rf_burst_reader.sv
// tb/tb_rf_burst_reader.sv - self-checking bench for rf_burst_reader with reg_file

module tb_rf_burst_reader;
    import rf_burst_reader_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    always #5 clk = ~clk;

    rf_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_rf (
        .clk  (clk),
        .we_i (we),
        .wa_i (wa),
        .wd_i (wd),
        .ra_i (bus.ra_o),
        .rd_o (bus.rd_i)
    );

    rf_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] model_mem [DEPTH];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] expect_word(input int addr);
        return (addr == 0) ? '0 : model_mem[addr];
    endfunction

    // Called and returns at a falling edge
    task automatic rf_write(input int a, input logic [DW-1:0] d);
        we = 1'b1;
        wa = AW'(a);
        wd = d;
        model_mem[a] = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Starts a burst at the current falling edge (cycle t) and checks every
    // cycle until the first idle cycle, where it returns.
    // Model: words appear from t+2 and stay presented back to back until the
    // last one is accepted; done follows the last acceptance by one cycle
    // (t+1 for an empty burst); busy spans t+1 through the done cycle.
    // mode 0: ready high, 1: ready low in first valid cycle then alternating,
    // 2: random ready. noise: random ignored start pulses while busy.
    task automatic run_burst(input int base, input int len, input int mode, input bit noise);
        int   c, idx, done_c, loaded;
        bit   exp_valid, exp_busy, finished;
        logic rdy;
        bus.start_i   = 1'b1;
        bus.base_i    = AW'(base);
        bus.len_i     = (AW + 1)'(len);
        bus.m_ready_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        idx      = 0;
        done_c   = (len == 0) ? 1 : -1;
        c        = 1;
        finished = 0;
        while (!finished) begin
            exp_valid = (c >= 2) && (idx < len);
            exp_busy  = (done_c < 0) || (c <= done_c);
            loaded    = idx + (exp_valid ? 1 : 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c >= 2) ? (((c - 2) % 2) == 1) : 1'b1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.m_ready_i = rdy;
            bus.start_i   = noise && exp_busy && ($urandom_range(0, 2) == 0);
            bus.base_i    = AW'($urandom);
            bus.len_i     = (AW + 1)'($urandom_range(0, DEPTH));

            check("busy",  DW'(bus.busy_o),    DW'(exp_busy));
            check("done",  DW'(bus.done_o),    DW'(c == done_c));
            check("valid", DW'(bus.m_valid_o), DW'(exp_valid));
            if (exp_valid) check("data", bus.m_data_o, expect_word((base + idx) % DEPTH));
            if (exp_busy)  check("ra",   DW'(bus.ra_o), DW'((base + loaded) % DEPTH));

            if (!exp_busy) begin
                finished = 1;
            end else if (c > 4000) begin
                check("timeout", 32'd1, 32'd0);
                $fatal(1, "burst did not complete");
            end else begin
                if (exp_valid && rdy) begin
                    idx++;
                    if (idx == len) done_c = c + 1;
                end
                @(negedge clk);
                c++;
            end
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        we            = 1'b0;
        wa            = '0;
        wd            = '0;
        bus.start_i   = 1'b0;
        bus.base_i    = '0;
        bus.len_i     = '0;
        bus.m_ready_i = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",  DW'(bus.busy_o),    '0);
        check("rst_done",  DW'(bus.done_o),    '0);
        check("rst_valid", DW'(bus.m_valid_o), '0);
        check("rst_data",  bus.m_data_o,       '0);
        check("rst_ra",    DW'(bus.ra_o),      '0);
        rst = 1'b0;

        for (int k = 0; k < DEPTH; k++) rf_write(k, DW'(32'h100 + k));

        // Directed cases; the first two run back to back for earliest restart
        run_burst(4, 4, 0, 0);
        run_burst(30, 4, 0, 0);
        run_burst(9, 3, 1, 0);
        run_burst(17, 0, 0, 0);
        run_burst(0, 32, 0, 1);

        // Reset during a len=8 burst after three words have gone out
        bus.start_i   = 1'b1;
        bus.base_i    = AW'(12);
        bus.len_i     = (AW + 1)'(8);
        bus.m_ready_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_data", bus.m_data_o, expect_word(14));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy",  DW'(bus.busy_o),    '0);
        check("mid_rst_done",  DW'(bus.done_o),    '0);
        check("mid_rst_valid", DW'(bus.m_valid_o), '0);
        check("mid_rst_data",  bus.m_data_o,       '0);
        check("mid_rst_ra",    DW'(bus.ra_o),      '0);
        @(negedge clk);
        check("post_rst_done", DW'(bus.done_o), '0);
        check("post_rst_busy", DW'(bus.busy_o), '0);
        run_burst(20, 5, 0, 0);

        // Randomised bursts with random register contents and random backpressure
        for (int n = 0; n < 20; n++) begin
            for (int w = 0; w < 3; w++) rf_write($urandom_range(0, DEPTH - 1), DW'($urandom));
            run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rf_burst_reader
